// File: rtl/scancode_decoder.sv
// PS/2 scancode decoder: resynchronises kb_done, strips F0/E0 prefixes, maps make codes to ASCII
// and queues them in a show-ahead FIFO. Optional shift tracking is enabled by defining SHIFT_TRACK_EN.
module scancode_decoder #(
  parameter int DEPTH       = 8,
  parameter int TIMEOUT_CYC = 500000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       kb_done,
  input  logic [7:0] kb_code,
  input  logic       rd_en,
  output logic [7:0] char_out,
  output logic       char_valid,
  output logic       fifo_full,
  output logic       overflow,
  output logic       shift_active
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(TIMEOUT_CYC);

  typedef enum logic [1:0] {S_IDLE, S_BRK, S_EXT, S_EXT_BRK} state_t;

  // Returns {mapped, is_letter, ascii}; letters come back lowercase.
  function automatic logic [9:0] map_code(input logic [7:0] code);
    case (code)
      8'h1C: map_code = {2'b11, 8'h61};
      8'h32: map_code = {2'b11, 8'h62};
      8'h21: map_code = {2'b11, 8'h63};
      8'h23: map_code = {2'b11, 8'h64};
      8'h24: map_code = {2'b11, 8'h65};
      8'h2B: map_code = {2'b11, 8'h66};
      8'h34: map_code = {2'b11, 8'h67};
      8'h33: map_code = {2'b11, 8'h68};
      8'h43: map_code = {2'b11, 8'h69};
      8'h3B: map_code = {2'b11, 8'h6A};
      8'h42: map_code = {2'b11, 8'h6B};
      8'h4B: map_code = {2'b11, 8'h6C};
      8'h3A: map_code = {2'b11, 8'h6D};
      8'h31: map_code = {2'b11, 8'h6E};
      8'h44: map_code = {2'b11, 8'h6F};
      8'h4D: map_code = {2'b11, 8'h70};
      8'h15: map_code = {2'b11, 8'h71};
      8'h2D: map_code = {2'b11, 8'h72};
      8'h1B: map_code = {2'b11, 8'h73};
      8'h2C: map_code = {2'b11, 8'h74};
      8'h3C: map_code = {2'b11, 8'h75};
      8'h2A: map_code = {2'b11, 8'h76};
      8'h1D: map_code = {2'b11, 8'h77};
      8'h22: map_code = {2'b11, 8'h78};
      8'h35: map_code = {2'b11, 8'h79};
      8'h1A: map_code = {2'b11, 8'h7A};
      8'h45: map_code = {2'b10, 8'h30};
      8'h16: map_code = {2'b10, 8'h31};
      8'h1E: map_code = {2'b10, 8'h32};
      8'h26: map_code = {2'b10, 8'h33};
      8'h25: map_code = {2'b10, 8'h34};
      8'h2E: map_code = {2'b10, 8'h35};
      8'h36: map_code = {2'b10, 8'h36};
      8'h3D: map_code = {2'b10, 8'h37};
      8'h3E: map_code = {2'b10, 8'h38};
      8'h46: map_code = {2'b10, 8'h39};
      8'h29: map_code = {2'b10, 8'h20};
      8'h5A: map_code = {2'b10, 8'h0D};
      8'h66: map_code = {2'b10, 8'h08};
      default: map_code = {2'b00, 8'h00};
    endcase
  endfunction

  logic [1:0]        sync_q, sync_d;
  logic              hist_q, hist_d;
  logic              byte_stb_s;
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  tmo_q, tmo_d;
  logic [7:0]        mem_q [DEPTH];
  logic [7:0]        mem_d [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [7:0]        char_out_q, char_out_d;
  logic              char_valid_q, char_valid_d;
  logic              fifo_full_q, fifo_full_d;
  logic              shift_active_q, shift_active_d;
  logic              shift_l_q, shift_l_d, shift_r_q, shift_r_d;
  logic              shift_hold_s;
  logic [9:0]        map_s;
  logic [7:0]        push_data_s;
  logic              push_s, pop_s, full_s, do_push_s;

  // kb_done crosses domains here; the edge history suppresses a strobe for a level held over reset.
  always_comb begin
    sync_d     = {sync_q[0], kb_done};
    hist_d     = sync_q[1];
    byte_stb_s = sync_q[1] & ~hist_q;
  end

`ifdef SHIFT_TRACK_EN
  assign shift_hold_s = shift_l_q | shift_r_q;
`else
  assign shift_hold_s = 1'b0;
`endif

  // Prefix-stripping FSM with idle timeout; byte strobes win over the timeout.
  always_comb begin
    state_d     = state_q;
    tmo_d       = tmo_q;
    push_s      = 1'b0;
    shift_l_d   = shift_l_q;
    shift_r_d   = shift_r_q;
    map_s       = map_code(kb_code);
    push_data_s = (map_s[8] && shift_hold_s) ? (map_s[7:0] - 8'h20) : map_s[7:0];
    if (byte_stb_s) begin
      tmo_d = '0;
      case (state_q)
        S_IDLE: begin
          if (kb_code == 8'hF0) begin
            state_d = S_BRK;
          end else if (kb_code == 8'hE0) begin
            state_d = S_EXT;
          end else begin
            push_s = map_s[9];
`ifdef SHIFT_TRACK_EN
            if (kb_code == 8'h12) begin
              shift_l_d = 1'b1;
            end else if (kb_code == 8'h59) begin
              shift_r_d = 1'b1;
            end else begin
              shift_l_d = shift_l_q;
            end
`endif
          end
        end
        S_BRK: begin
          state_d = S_IDLE;
`ifdef SHIFT_TRACK_EN
          if (kb_code == 8'h12) begin
            shift_l_d = 1'b0;
          end else if (kb_code == 8'h59) begin
            shift_r_d = 1'b0;
          end else begin
            shift_l_d = shift_l_q;
          end
`endif
        end
        S_EXT: begin
          if (kb_code == 8'hF0) begin
            state_d = S_EXT_BRK;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_EXT_BRK: state_d = S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end else if (state_q == S_IDLE) begin
      tmo_d = '0;
    end else if (tmo_q == CNT_W'(TIMEOUT_CYC - 1)) begin
      state_d = S_IDLE;
      tmo_d   = '0;
    end else begin
      tmo_d = tmo_q + CNT_W'(1);
    end
  end

  // FIFO bookkeeping; the registered head is taken from next-state pointers so it needs no extra cycle.
  always_comb begin
    mem_d     = mem_q;
    pop_s     = rd_en & (count_q != '0);
    full_s    = (count_q == (ADDR_W+1)'(DEPTH));
    do_push_s = push_s & (~full_s | pop_s);
    overflow_d = overflow_q | (push_s & full_s & ~pop_s);
    wr_ptr_d  = do_push_s ? (wr_ptr_q + ADDR_W'(1)) : wr_ptr_q;
    rd_ptr_d  = pop_s ? (rd_ptr_q + ADDR_W'(1)) : rd_ptr_q;
    case ({do_push_s, pop_s})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase
    if (do_push_s) begin
      mem_d[wr_ptr_q] = push_data_s;
    end else begin
      mem_d[wr_ptr_q] = mem_q[wr_ptr_q];
    end
    if (count_d == '0) begin
      char_out_d = 8'h00;
    end else if (do_push_s && (rd_ptr_d == wr_ptr_q)) begin
      char_out_d = push_data_s;
    end else begin
      char_out_d = mem_q[rd_ptr_d];
    end
    char_valid_d   = (count_d != '0);
    fifo_full_d    = (count_d == (ADDR_W+1)'(DEPTH));
    shift_active_d = shift_l_d | shift_r_d;
  end

  // State register for synchroniser, FSM, FIFO and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q         <= 2'b11;
      hist_q         <= 1'b1;
      state_q        <= S_IDLE;
      tmo_q          <= '0;
      mem_q          <= '{default: 8'h00};
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      overflow_q     <= 1'b0;
      char_out_q     <= 8'h00;
      char_valid_q   <= 1'b0;
      fifo_full_q    <= 1'b0;
      shift_l_q      <= 1'b0;
      shift_r_q      <= 1'b0;
      shift_active_q <= 1'b0;
    end else begin
      sync_q         <= sync_d;
      hist_q         <= hist_d;
      state_q        <= state_d;
      tmo_q          <= tmo_d;
      mem_q          <= mem_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      overflow_q     <= overflow_d;
      char_out_q     <= char_out_d;
      char_valid_q   <= char_valid_d;
      fifo_full_q    <= fifo_full_d;
      shift_l_q      <= shift_l_d;
      shift_r_q      <= shift_r_d;
      shift_active_q <= shift_active_d;
    end
  end

  assign char_out     = char_out_q;
  assign char_valid   = char_valid_q;
  assign fifo_full    = fifo_full_q;
  assign overflow     = overflow_q;
  assign shift_active = shift_active_q;

endmodule

// File: tb/tb_scancode_decoder.sv
// Directed bench for scancode_decoder: a transaction-level model (prefix state, key tables, char queue)
// is compared against the outputs every cycle, plus literal checks per scenario.
module tb_scancode_decoder;

  localparam int DEPTH = 8;
  localparam int TMO   = 20;
  localparam int NORMAL_GAP = 4;
  localparam int LONG_GAP   = TMO + 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       kb_done = 1'b0;
  logic [7:0] kb_code = 8'h00;
  logic       rd_en = 1'b0;
  logic [7:0] char_out;
  logic       char_valid, fifo_full, overflow, shift_active;

  scancode_decoder #(.DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
    .clock(clock), .reset(reset), .kb_done(kb_done), .kb_code(kb_code), .rd_en(rd_en),
    .char_out(char_out), .char_valid(char_valid), .fifo_full(fifo_full),
    .overflow(overflow), .shift_active(shift_active)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model state
  logic [7:0] mq[$];
  bit m_ovf = 1'b0;
  bit m_shl = 1'b0, m_shr = 1'b0;
  int m_state = 0;   // 0 idle, 1 break, 2 extended, 3 extended break
  int prev_gap = 0;

  logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                    8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                    8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clock) begin
    if (chk_en) begin
      check("valid", {31'd0, char_valid}, {31'd0, mq.size() != 0});
      check("head", {24'd0, char_out}, (mq.size() != 0) ? {24'd0, mq[0]} : 32'd0);
      check("full", {31'd0, fifo_full}, {31'd0, mq.size() == DEPTH});
      check("ovf", {31'd0, overflow}, {31'd0, m_ovf});
      check("shift", {31'd0, shift_active}, {31'd0, m_shl | m_shr});
    end
  end

  task automatic model_reset();
    mq.delete();
    m_ovf = 1'b0; m_shl = 1'b0; m_shr = 1'b0; m_state = 0;
  endtask

  task automatic model_step(input logic [7:0] code, input bit with_pop, input int gap_before);
    bit push = 1'b0;
    bit popped;
    int size_before;
    logic [7:0] ch = 8'h00;
    if (gap_before > TMO) m_state = 0;
    case (m_state)
      0: begin
        if (code == 8'hF0) m_state = 1;
        else if (code == 8'hE0) m_state = 2;
        else begin
          for (int i = 0; i < 26; i++)
            if (letter_codes[i] == code) begin
              push = 1'b1;
              ch = 8'(int'("a") + i);
`ifdef SHIFT_TRACK_EN
              if (m_shl || m_shr) ch = 8'(int'("A") + i);
`endif
            end
          for (int i = 0; i < 10; i++)
            if (digit_codes[i] == code) begin push = 1'b1; ch = 8'(int'("0") + i); end
          if (code == 8'h29) begin push = 1'b1; ch = 8'h20; end
          if (code == 8'h5A) begin push = 1'b1; ch = 8'h0D; end
          if (code == 8'h66) begin push = 1'b1; ch = 8'h08; end
`ifdef SHIFT_TRACK_EN
          if (code == 8'h12) m_shl = 1'b1;
          if (code == 8'h59) m_shr = 1'b1;
`endif
        end
      end
      1: begin
`ifdef SHIFT_TRACK_EN
        if (code == 8'h12) m_shl = 1'b0;
        if (code == 8'h59) m_shr = 1'b0;
`endif
        m_state = 0;
      end
      2: m_state = (code == 8'hF0) ? 3 : 0;
      default: m_state = 0;
    endcase
    size_before = mq.size();
    popped = with_pop && (size_before > 0);
    if (popped) void'(mq.pop_front());
    if (push) begin
      if (size_before < DEPTH || popped) mq.push_back(ch);
      else m_ovf = 1'b1;
    end
  endtask

  // One PS/2 byte: the result is visible after the third rising edge from kb_done rising.
  task automatic send_byte(input logic [7:0] code, input bit with_pop, input int gap);
    @(negedge clock);
    kb_code = code;
    kb_done = 1'b1;
    @(posedge clock);
    @(posedge clock);
    if (with_pop) begin
      @(negedge clock);
      rd_en = 1'b1;
    end
    @(posedge clock);
    #1 model_step(code, with_pop, prev_gap);
    @(negedge clock);
    kb_done = 1'b0;
    rd_en = 1'b0;
    repeat (gap) @(negedge clock);
    prev_gap = gap;
  endtask

  task automatic pop_one();
    @(negedge clock);
    rd_en = 1'b1;
    @(posedge clock);
    #1 if (mq.size() > 0) void'(mq.pop_front());
    @(negedge clock);
    rd_en = 1'b0;
  endtask

  task automatic do_reset(input bit hold_done);
    @(negedge clock);
    reset = 1'b1;
    kb_done = hold_done;
    @(posedge clock);
    #1 model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    prev_gap = 0;
  endtask

  initial begin
    @(posedge clock);
    #1 model_reset();
    chk_en = 1'b1;
    do_reset(1'b0);
    @(negedge clock);
    check("rst_valid", {31'd0, char_valid}, 32'd0);
    check("rst_out", {24'd0, char_out}, 32'd0);
    check("rst_full", {31'd0, fifo_full}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    check("rst_shift", {31'd0, shift_active}, 32'd0);

    // 1: make/break of 'a'
    send_byte(8'h1C, 1'b0, NORMAL_GAP);
    send_byte(8'hF0, 1'b0, NORMAL_GAP);
    send_byte(8'h1C, 1'b0, NORMAL_GAP);
    check("t1_out", {24'd0, char_out}, 32'h61);
    check("t1_valid", {31'd0, char_valid}, 32'd1);
    pop_one();
    @(negedge clock);
    check("t1_empty", {31'd0, char_valid}, 32'd0);

    // 2: extended make/break ignored, then 'f'
    send_byte(8'hE0, 1'b0, NORMAL_GAP);
    send_byte(8'h75, 1'b0, NORMAL_GAP);
    send_byte(8'hE0, 1'b0, NORMAL_GAP);
    send_byte(8'hF0, 1'b0, NORMAL_GAP);
    send_byte(8'h75, 1'b0, NORMAL_GAP);
    check("t2_none", {31'd0, char_valid}, 32'd0);
    send_byte(8'h2B, 1'b0, NORMAL_GAP);
    check("t2_out", {24'd0, char_out}, 32'h66);
    pop_one();

    // 3: overflow, then simultaneous push and pop at full
    for (int i = 0; i < DEPTH + 1; i++) send_byte(8'h16, 1'b0, NORMAL_GAP);
    check("t3_full", {31'd0, fifo_full}, 32'd1);
    check("t3_ovf", {31'd0, overflow}, 32'd1);
    check("t3_out", {24'd0, char_out}, 32'h31);
    check("t3_count", mq.size(), DEPTH);
    send_byte(8'h16, 1'b1, NORMAL_GAP);
    check("t3_full_pp", {31'd0, fifo_full}, 32'd1);
    check("t3_count_pp", mq.size(), DEPTH);
    for (int i = 0; i < DEPTH; i++) pop_one();
    @(negedge clock);
    check("t3_drained", {31'd0, char_valid}, 32'd0);
    pop_one();  // pop on empty is ignored

    // 4: break prefix times out, next byte is a make
    send_byte(8'hF0, 1'b0, LONG_GAP);
    send_byte(8'h24, 1'b0, NORMAL_GAP);
    check("t4_out", {24'd0, char_out}, 32'h65);
    check("t4_valid", {31'd0, char_valid}, 32'd1);

    // 5: reset mid-queue with kb_done held high across release
    send_byte(8'h1C, 1'b0, NORMAL_GAP);
    do_reset(1'b1);
    @(negedge clock);
    check("t5_valid", {31'd0, char_valid}, 32'd0);
    check("t5_ovf", {31'd0, overflow}, 32'd0);
    repeat (4) @(negedge clock);
    kb_done = 1'b0;
    repeat (6) @(negedge clock);
    check("t5_nopush", {31'd0, char_valid}, 32'd0);

    // Space, enter, backspace, digit 9 and an unmapped code
    send_byte(8'h29, 1'b0, NORMAL_GAP);
    send_byte(8'h5A, 1'b0, NORMAL_GAP);
    send_byte(8'h66, 1'b0, NORMAL_GAP);
    send_byte(8'h0E, 1'b0, NORMAL_GAP);
    send_byte(8'h46, 1'b0, NORMAL_GAP);
    send_byte(8'h12, 1'b0, NORMAL_GAP);
    send_byte(8'h1A, 1'b0, NORMAL_GAP);
    check("misc_head", {24'd0, char_out}, 32'h20);
    for (int i = 0; i < 5; i++) pop_one();
`ifdef SHIFT_TRACK_EN
    send_byte(8'hF0, 1'b0, NORMAL_GAP);
    send_byte(8'h12, 1'b0, NORMAL_GAP);
`endif

`ifdef SHIFT_TRACK_EN
    // 6: shifted and unshifted 'a'
    send_byte(8'h12, 1'b0, NORMAL_GAP);
    check("t6_shift_on", {31'd0, shift_active}, 32'd1);
    send_byte(8'h1C, 1'b0, NORMAL_GAP);
    check("t6_upper", {24'd0, char_out}, 32'h41);
    send_byte(8'hF0, 1'b0, NORMAL_GAP);
    send_byte(8'h1C, 1'b0, NORMAL_GAP);
    send_byte(8'hF0, 1'b0, NORMAL_GAP);
    send_byte(8'h12, 1'b0, NORMAL_GAP);
    check("t6_shift_off", {31'd0, shift_active}, 32'd0);
    send_byte(8'h1C, 1'b0, NORMAL_GAP);
    pop_one();
    @(negedge clock);
    check("t6_lower", {24'd0, char_out}, 32'h61);
`endif

    repeat (4) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
